// File: rtl/tx_seq_pkg.sv
// Shared definitions for the word-to-byte transmit sequencer.
//   state_t        : serializer FSM state encoding
//   BYTES_PER_WORD : bytes sent per pushed word, least-significant first
package tx_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_WAIT = 2'b10
    } state_t;

    localparam int BYTES_PER_WORD = 4;

endpackage : tx_seq_pkg

// File: rtl/word_fifo.sv
// Word FIFO feeding the transmit serializer.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   push       : write wr_data this cycle (ignored while full, even with a pop)
//   pop        : advance the read pointer (ignored while empty)
//   flush      : synchronous clear of pointers and count; beats push and pop
//   wr_data    : word to write
//   rd_data    : head word (combinational read at the read pointer)
//   full/empty : decoded from the registered occupancy count
//   count      : occupancy, 0..FIFO_DEPTH
module word_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic                  push_ok;
    logic                  pop_ok;

    // A push is judged against the registered full flag only, so a pop in
    // the same cycle never makes room for it.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);

endmodule : word_fifo

// File: rtl/tx_word_sequencer.sv
// Buffers 32-bit words and feeds them byte by byte (LSB first) to a UART TX.
// Ports:
//   i_clk, i_reset : clock and asynchronous active-low reset
//   i_wr_en        : push strobe, one word per high cycle
//   i_wr_data      : word to push
//   i_flush        : synchronous clear of the FIFO and the serializer
//   i_tx_done      : pulse from the UART when the current byte is out
//   o_tx_start     : one-cycle request to send o_tx_byte
//   o_tx_byte      : byte to send, stable from o_tx_start until i_tx_done
//   o_full/o_empty : FIFO occupancy flags
//   o_busy         : serializer is working on a word
//   o_overflow     : sticky, a push was dropped because the FIFO was full
module tx_word_sequencer
    import tx_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_flush,
    input  logic                  i_tx_done,
    output logic                  o_tx_start,
    output logic [7:0]            o_tx_byte,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_busy,
    output logic                  o_overflow
);

    state_t                      state;
    state_t                      state_nxt;
    logic [1:0]                  byte_cnt;
    logic [DATA_WIDTH-1:0]       shift;
    logic [DATA_WIDTH-1:0]       fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        pop;
    logic                        load;
    logic                        adv;

    word_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (i_reset),
        .push    (i_wr_en),
        .pop     (pop),
        .flush   (i_flush),
        .wr_data (i_wr_data),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign o_full  = fifo_full;
    assign o_empty = fifo_empty;

    // o_tx_start is registered from the SEND state, so it is high during the
    // first WAIT cycle. i_tx_done is only honoured in WAIT once that pulse has
    // dropped, which keeps a done coinciding with the start from advancing.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        adv       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fifo_count != '0) begin
                    pop       = 1'b1;
                    load      = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (i_tx_done && !o_tx_start) begin
                    if (byte_cnt == 2'(BYTES_PER_WORD - 1)) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        adv       = 1'b1;
                        state_nxt = ST_SEND;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (i_flush) begin
            state_nxt = ST_IDLE;
            pop       = 1'b0;
            load      = 1'b0;
            adv       = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state      <= ST_IDLE;
            byte_cnt   <= '0;
            o_tx_start <= 1'b0;
            o_tx_byte  <= 8'h00;
            o_busy     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load || i_flush) begin
                byte_cnt <= '0;
            end else if (adv) begin
                byte_cnt <= byte_cnt + 2'd1;
            end
            o_tx_start <= (state == ST_SEND) && !i_flush;
            if ((state == ST_SEND) && !i_flush) o_tx_byte <= shift[7:0];
            o_busy <= (state_nxt != ST_IDLE);
            if (i_flush) begin
                o_overflow <= 1'b0;
            end else if (i_wr_en && fifo_full) begin
                o_overflow <= 1'b1;
            end
        end
    end

    // Word being serialized; the next byte always sits in the low 8 bits.
    always_ff @(posedge i_clk) begin
        if (load) begin
            shift <= fifo_head;
        end else if (adv) begin
            shift <= shift >> 8;
        end
    end

endmodule : tx_word_sequencer
